led_pwm_sequencer: RTL and testbench

//  Scheduler for a bank of channels_p led_pwm instances. Generates the
//  en/incr/decr pulses that make every channel "breathe" through a

---
 rtl/led_pwm_seq_pkg.sv | 22 ++
 rtl/led_pwm_seq_chan.sv | 102 ++++++++++
 rtl/led_pwm_sequencer.sv | 108 ++++++++++
 tb/tb_led_pwm_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/led_pwm_seq_pkg.sv
// Shared types for the led_pwm breathing sequencer.
// Top FSM and per-channel FSM encodings plus a width helper.
package led_pwm_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } seq_state_e;

  typedef enum logic [1:0] {
    UP,
    HOLD_HI,
    DOWN,
    HOLD_LO
  } chan_state_e;

  function automatic int unsigned cw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_pwm_seq_chan.sv
// One breathing channel: level shadow, hold counter and channel FSM.
// Pulses are registered so they line up with the level_o update.
module led_pwm_seq_chan
  import led_pwm_seq_pkg::*;
#(
  parameter int unsigned bits_p       = 4,
  parameter int unsigned hold_steps_p = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              step_i,
  input  logic              drain_i,
  input  logic              clr_i,
  output logic              incr_o,
  output logic              decr_o,
  output logic [bits_p-1:0] level_o,
  output logic              zero_o
);

  localparam int unsigned HW = cw(hold_steps_p);
  localparam logic [bits_p-1:0] TOP = '1;
  localparam logic [bits_p-1:0] ONE = bits_p'(1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(hold_steps_p - 1);

  chan_state_e       st_q, st_d;
  logic [bits_p-1:0] lvl_q, lvl_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic              incr_q, incr_d;
  logic              decr_q, decr_d;

  assign zero_o  = (lvl_q == '0);
  assign level_o = lvl_q;
  assign incr_o  = incr_q;
  assign decr_o  = decr_q;

  always_comb begin
    st_d   = st_q;
    lvl_d  = lvl_q;
    hold_d = hold_q;
    incr_d = 1'b0;
    decr_d = 1'b0;
    if (clr_i) begin
      st_d   = UP;
      lvl_d  = '0;
      hold_d = '0;
    end else if (drain_i) begin
      if (step_i) begin
        st_d   = UP;
        hold_d = '0;
        if (!zero_o) begin
          decr_d = 1'b1;
          lvl_d  = lvl_q - ONE;
        end
      end
    end else if (step_i) begin
      unique case (st_q)
        UP: begin
          incr_d = 1'b1;
          lvl_d  = lvl_q + ONE;
          if (lvl_d == TOP) begin
            st_d   = HOLD_HI;
            hold_d = '0;
          end
        end
        DOWN: begin
          decr_d = 1'b1;
          lvl_d  = lvl_q - ONE;
          if (lvl_d == '0) begin
            st_d   = HOLD_LO;
            hold_d = '0;
          end
        end
        HOLD_HI, HOLD_LO: begin
          if (hold_q == HOLD_LAST) begin
            st_d   = (st_q == HOLD_HI) ? DOWN : UP;
            hold_d = '0;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        default: st_d = UP;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      st_q   <= UP;
      lvl_q  <= '0;
      hold_q <= '0;
      incr_q <= 1'b0;
      decr_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      lvl_q  <= lvl_d;
      hold_q <= hold_d;
      incr_q <= incr_d;
      decr_q <= decr_d;
    end
  end

endmodule

// File: rtl/led_pwm_sequencer.sv
// Round-robin breathing scheduler for a bank of led_pwm channels.
// One prescaled tick steps one channel; stop drains all levels to zero.
module led_pwm_sequencer
  import led_pwm_seq_pkg::*;
#(
  parameter int unsigned channels_p   = 4,
  parameter int unsigned bits_p       = 4,
  parameter int unsigned tick_div_p   = 65536,
  parameter int unsigned hold_steps_p = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         en_i,
  input  logic                         start_i,
  input  logic                         stop_i,
  output logic [channels_p-1:0]        en_o,
  output logic [channels_p-1:0]        incr_o,
  output logic [channels_p-1:0]        decr_o,
  output logic [channels_p*bits_p-1:0] level_o,
  output logic                         busy_o
);

  localparam int unsigned PW  = cw(tick_div_p);
  localparam int unsigned PTW = cw(channels_p);
  localparam logic [PW-1:0]  PRE_LAST = PW'(tick_div_p - 1);
  localparam logic [PTW-1:0] PTR_LAST = PTW'(channels_p - 1);

  seq_state_e       state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [PTW-1:0]   ptr_q, ptr_d;
  logic             run_entry;
  logic             tick;
  logic             drain;
  logic [channels_p-1:0] step;
  logic [channels_p-1:0] zero;

  assign busy_o = (state_q != IDLE);
  assign en_o   = {channels_p{busy_o}};
  assign drain  = (state_q == DRAIN);
  assign tick   = en_i && busy_o && (presc_q == PRE_LAST);

  // stop beats start; everything holds while en_i is low
  always_comb begin
    state_d   = state_q;
    run_entry = 1'b0;
    if (en_i) begin
      unique case (state_q)
        IDLE: begin
          if (start_i && !stop_i) begin
            state_d   = RUN;
            run_entry = 1'b1;
          end
        end
        RUN:     if (stop_i) state_d = DRAIN;
        DRAIN:   if (&zero) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    presc_d = presc_q;
    ptr_d   = ptr_q;
    if (run_entry) begin
      presc_d = '0;
      ptr_d   = '0;
    end else if (en_i && busy_o) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTW'(1);
    end
  end

  always_comb begin
    step = '0;
    for (int k = 0; k < channels_p; k++)
      step[k] = tick && (ptr_q == PTW'(k));
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      presc_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      ptr_q   <= ptr_d;
    end
  end

  for (genvar k = 0; k < channels_p; k++) begin : g_chan
    led_pwm_seq_chan #(
      .bits_p       (bits_p),
      .hold_steps_p (hold_steps_p)
    ) u_chan (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .step_i  (step[k]),
      .drain_i (drain),
      .clr_i   (run_entry),
      .incr_o  (incr_o[k]),
      .decr_o  (decr_o[k]),
      .level_o (level_o[k*bits_p +: bits_p]),
      .zero_o  (zero[k])
    );
  end

endmodule

// File: tb/tb_led_pwm_sequencer.sv
// Directed bench for led_pwm_sequencer (2 channels, 2-bit, div 4, hold 2).
// A behavioural led_pwm duty model tracks the pulses it would consume.
module tb_led_pwm_sequencer;

  localparam int CH = 2;
  localparam int BW = 2;

  logic clk_i = 1'b0;
  logic reset_i, en_i, start_i, stop_i;
  logic [CH-1:0]    en_o, incr_o, decr_o;
  logic [CH*BW-1:0] level_o;
  logic             busy_o;

  int n_vec = 0;
  int n_err = 0;
  int duty [CH];

  led_pwm_sequencer #(
    .channels_p   (CH),
    .bits_p       (BW),
    .tick_div_p   (4),
    .hold_steps_p (2)
  ) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (en_i),
    .start_i (start_i),
    .stop_i  (stop_i),
    .en_o    (en_o),
    .incr_o  (incr_o),
    .decr_o  (decr_o),
    .level_o (level_o),
    .busy_o  (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one edge, sample 1ns later, let the duty model consume pulses
  task automatic clk1();
    @(posedge clk_i);
    #1;
    for (int c = 0; c < CH; c++) begin
      if (en_o[c] && incr_o[c]) duty[c]++;
      if (en_o[c] && decr_o[c]) duty[c]--;
    end
  endtask

  // ch level after its k-th step (k from 0): up 3, hold 2, down 3, hold 2
  function automatic int lv(input int k);
    if (k < 0) return 0;
    case (k % 10)
      0:       return 1;
      1:       return 2;
      2, 3, 4: return 3;
      5:       return 2;
      6:       return 1;
      default: return 0;
    endcase
  endfunction

  initial begin
    logic [1:0] ei, ed;
    logic [3:0] el;
    int idx, c, k, l0, l1;

    duty[0] = 0;
    duty[1] = 0;
    reset_i = 1'b1;
    en_i    = 1'b1;
    start_i = 1'b0;
    stop_i  = 1'b0;
    clk1();
    clk1();
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_en", 32'(en_o), 32'd0);
    chk("rst_pulse", 32'({incr_o, decr_o}), 32'd0);
    chk("rst_level", 32'(level_o), 32'd0);
    reset_i = 1'b0;
    clk1();
    chk("idle_busy", 32'(busy_o), 32'd0);

    // run 200 cycles from start at edge 0
    start_i = 1'b1;
    clk1();
    start_i = 1'b0;
    chk("A_busy0", 32'(busy_o), 32'd1);
    chk("A_en0", 32'(en_o), 32'd3);
    for (int e = 1; e < 200; e++) begin
      clk1();
      ei = '0;
      ed = '0;
      if (e % 4 == 0) begin
        idx = e / 4 - 1;
        c   = idx % 2;
        k   = idx / 2;
        if (lv(k) > lv(k - 1)) ei[c] = 1'b1;
        else if (lv(k) < lv(k - 1)) ed[c] = 1'b1;
      end
      l0 = lv(((e >= 4) ? (e - 4) / 8 + 1 : 0) - 1);
      l1 = lv(((e >= 8) ? (e - 8) / 8 + 1 : 0) - 1);
      el = {2'(l1), 2'(l0)};
      chk("A_incr", 32'(incr_o), 32'(ei));
      chk("A_decr", 32'(decr_o), 32'(ed));
      chk("A_level", 32'(level_o), 32'(el));
      chk("A_shadow", 32'(level_o), 32'({2'(duty[1]), 2'(duty[0])}));
      chk("A_busy", 32'(busy_o), 32'd1);
    end

    // asynchronous reset mid-RUN
    reset_i = 1'b1;
    duty[0] = 0;
    duty[1] = 0;
    #1;
    chk("R_async", 32'({busy_o, en_o, incr_o, decr_o, level_o}), 32'd0);
    clk1();
    reset_i = 1'b0;
    for (int e = 0; e < 20; e++) begin
      clk1();
      chk("R_quiet", 32'({busy_o, en_o, incr_o, decr_o, level_o}), 32'd0);
    end

    // run to level0=3, level1=2, then start+stop together, start in DRAIN
    start_i = 1'b1;
    clk1();
    start_i = 1'b0;
    for (int e = 1; e <= 21; e++) clk1();
    chk("B_pre_level", 32'(level_o), 32'hB);
    for (int e = 22; e <= 46; e++) begin
      start_i = (e == 22) || (e == 30);
      stop_i  = (e == 22);
      clk1();
      start_i = 1'b0;
      stop_i  = 1'b0;
      ed = 2'b00;
      if (e == 24 || e == 32) ed = 2'b10;
      if (e == 28 || e == 36 || e == 44) ed = 2'b01;
      l1 = (e < 24) ? 2 : (e < 32) ? 1 : 0;
      l0 = (e < 28) ? 3 : (e < 36) ? 2 : (e < 44) ? 1 : 0;
      el = {2'(l1), 2'(l0)};
      chk("B_incr", 32'(incr_o), 32'd0);
      chk("B_decr", 32'(decr_o), 32'(ed));
      chk("B_level", 32'(level_o), 32'(el));
      chk("B_busy", 32'(busy_o), (e <= 44) ? 32'd1 : 32'd0);
    end

    // en_i low for 20 edges mid-RUN
    start_i = 1'b1;
    clk1();
    start_i = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      en_i = !(e >= 11 && e <= 30);
      clk1();
      ei = 2'b00;
      if (e == 4 || e == 32 || e == 40) ei = 2'b01;
      if (e == 8 || e == 36) ei = 2'b10;
      l0 = (e < 4) ? 0 : (e < 32) ? 1 : (e < 40) ? 2 : 3;
      l1 = (e < 8) ? 0 : (e < 36) ? 1 : 2;
      el = {2'(l1), 2'(l0)};
      chk("C_incr", 32'(incr_o), 32'(ei));
      chk("C_decr", 32'(decr_o), 32'd0);
      chk("C_level", 32'(level_o), 32'(el));
      chk("C_en", 32'(en_o), 32'd3);
    end
    en_i = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
